// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM state type and opcode classification helpers
// for the ALU result reader.
package alu_pkg;

    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_OR  = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_NEG = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;
    localparam logic [3:0] OP_ROL = 4'd8;
    localparam logic [3:0] OP_ROR = 4'd9;
    localparam logic [3:0] OP_MUL = 4'd10;
    localparam logic [3:0] OP_DIV = 4'd11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CAPTURE,
        ST_SEND_LO,
        ST_SEND_HI
    } state_t;

    // Multiply and divide produce a 64-bit result split across C_LO/C_HI.
    function automatic logic is_wide(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

    function automatic logic is_legal(input logic [3:0] op);
        return op <= OP_DIV;
    endfunction

endpackage

// File: rtl/alu_z_settle_ctr.sv
// Loadable down-counter timing the ALU settle window; done flags the last
// settle cycle so the FSM can move to capture on the following edge.
module alu_z_settle_ctr #(
    parameter int WIDTH = 3
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             done
);

    logic [WIDTH-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign done = (count == WIDTH'(1));

endmodule

// File: rtl/alu_z_reader.sv
// Consumer side of the combinational ALU: registers a request into the ALU,
// waits for it to settle, captures C_LO/C_HI and streams them over valid/ready.
module alu_z_reader
    import alu_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ALU_LAT    = 1,
    parameter int MULDIV_LAT = 4
) (
    input  logic              clock,
    input  logic              clear_n,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [3:0]        op_cntrl,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_cntrl,
    input  logic [DATA_W-1:0] alu_c_lo,
    input  logic [DATA_W-1:0] alu_c_hi,
    output logic [DATA_W-1:0] z_lo,
    output logic [DATA_W-1:0] z_hi,
    output logic              bus_valid,
    input  logic              bus_ready,
    output logic [DATA_W-1:0] bus_data,
    output logic              bus_last,
    output logic              op_err
);

    localparam int MAX_LAT = (ALU_LAT > MULDIV_LAT) ? ALU_LAT : MULDIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;

    state_t           state;
    logic             accept;
    logic             settle_done;
    logic [CNT_W-1:0] settle_val;

    assign accept     = (state == ST_IDLE) && op_valid && op_ready;
    assign settle_val = is_wide(op_cntrl) ? CNT_W'(MULDIV_LAT) : CNT_W'(ALU_LAT);

    alu_z_settle_ctr #(.WIDTH(CNT_W)) u_settle_ctr (
        .clock    (clock),
        .clear_n  (clear_n),
        .load     (accept),
        .load_val (settle_val),
        .dec      (state == ST_SETTLE),
        .done     (settle_done)
    );

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state     <= ST_IDLE;
            op_ready  <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_cntrl <= '0;
            z_lo      <= '0;
            z_hi      <= '0;
            bus_valid <= 1'b0;
            bus_data  <= '0;
            bus_last  <= 1'b0;
            op_err    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    op_ready <= 1'b1;
                    if (accept) begin
                        alu_a     <= op_a;
                        alu_b     <= op_b;
                        alu_cntrl <= op_cntrl;
                        op_ready  <= 1'b0;
                        state     <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (settle_done) state <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    // bus_data is loaded alongside z_lo so the first beat is ready on entry.
                    if (!is_legal(alu_cntrl)) begin
                        z_lo     <= '0;
                        z_hi     <= '0;
                        bus_data <= '0;
                        bus_last <= 1'b1;
                        op_err   <= 1'b1;
                    end else begin
                        z_lo     <= alu_c_lo;
                        z_hi     <= is_wide(alu_cntrl) ? alu_c_hi : '0;
                        bus_data <= alu_c_lo;
                        bus_last <= !is_wide(alu_cntrl);
                    end
                    bus_valid <= 1'b1;
                    state     <= ST_SEND_LO;
                end
                ST_SEND_LO: begin
                    if (bus_ready) begin
                        if (is_wide(alu_cntrl)) begin
                            bus_data <= z_hi;
                            bus_last <= 1'b1;
                            state    <= ST_SEND_HI;
                        end else begin
                            bus_valid <= 1'b0;
                            bus_last  <= 1'b0;
                            op_ready  <= 1'b1;
                            state     <= ST_IDLE;
                        end
                    end
                end
                ST_SEND_HI: begin
                    if (bus_ready) begin
                        bus_valid <= 1'b0;
                        bus_last  <= 1'b0;
                        op_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_z_reader.sv
// Directed self-checking bench for alu_z_reader with a behavioural ALU
// attached to the alu_* / alu_c_* interface.
module tb_alu_z_reader;

    localparam int DATA_W = 32;

    logic              clock = 1'b0;
    logic              clear_n = 1'b0;
    logic              op_valid = 1'b0;
    logic              op_ready;
    logic [3:0]        op_cntrl = '0;
    logic [DATA_W-1:0] op_a = '0;
    logic [DATA_W-1:0] op_b = '0;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [3:0]        alu_cntrl;
    logic [DATA_W-1:0] alu_c_lo;
    logic [DATA_W-1:0] alu_c_hi;
    logic [DATA_W-1:0] z_lo;
    logic [DATA_W-1:0] z_hi;
    logic              bus_valid;
    logic              bus_ready = 1'b0;
    logic [DATA_W-1:0] bus_data;
    logic              bus_last;
    logic              op_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    alu_z_reader #(.DATA_W(DATA_W), .ALU_LAT(1), .MULDIV_LAT(4)) dut (
        .clock     (clock),
        .clear_n   (clear_n),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_cntrl  (op_cntrl),
        .op_a      (op_a),
        .op_b      (op_b),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_cntrl (alu_cntrl),
        .alu_c_lo  (alu_c_lo),
        .alu_c_hi  (alu_c_hi),
        .z_lo      (z_lo),
        .z_hi      (z_hi),
        .bus_valid (bus_valid),
        .bus_ready (bus_ready),
        .bus_data  (bus_data),
        .bus_last  (bus_last),
        .op_err    (op_err)
    );

    // C_HI is deliberately junk for 32-bit ops so zeroing of z_hi is visible.
    always_comb begin
        logic [63:0] prod;
        prod     = 64'(alu_a) * 64'(alu_b);
        alu_c_hi = 32'hDEAD_BEEF;
        case (alu_cntrl)
            4'd0:    alu_c_lo = alu_a & alu_b;
            4'd1:    alu_c_lo = alu_a | alu_b;
            4'd2:    alu_c_lo = alu_a + alu_b;
            4'd3:    alu_c_lo = alu_a - alu_b;
            4'd10: begin
                alu_c_lo = prod[31:0];
                alu_c_hi = prod[63:32];
            end
            4'd11: begin
                alu_c_lo = (alu_b != 0) ? alu_a / alu_b : '1;
                alu_c_hi = (alu_b != 0) ? alu_a % alu_b : alu_a;
            end
            default: alu_c_lo = 32'hFFFF_FFFF;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Presents a request and returns just after the edge that accepts it.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        int n;
        op_a = a;
        op_b = b;
        op_cntrl = op;
        op_valid = 1'b1;
        n = 0;
        while (!op_ready && n < 40) begin
            tick();
            n++;
        end
        if (!op_ready) check("accept_timeout", 32'(op_ready), 32'd1);
        tick();
        op_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int exp_lat);
        int n;
        n = 0;
        while (!bus_valid && n < 40) begin
            tick();
            n++;
        end
        check(tag, 32'(n), 32'(exp_lat));
    endtask

    task automatic get_beat(input string tag, input logic [31:0] exp_data,
                            input logic exp_last, input int stall);
        int n;
        n = 0;
        while (!bus_valid && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, 32'(bus_valid), 32'd1);
        for (int i = 0; i < stall; i++) begin
            bus_ready = 1'b0;
            tick();
            check({tag, "_hold"}, bus_data, exp_data);
        end
        check({tag, "_data"}, bus_data, exp_data);
        check({tag, "_last"}, 32'(bus_last), 32'(exp_last));
        bus_ready = 1'b1;
        tick();
        bus_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] or_a [3];
        logic [31:0] or_b [3];
        int seen_valid;
        or_a = '{32'h1, 32'h4, 32'h10};
        or_b = '{32'h2, 32'h8, 32'h01};

        #12;
        check("rst_bus_valid", 32'(bus_valid), 32'd0);
        check("rst_op_ready", 32'(op_ready), 32'd0);
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_alu_cntrl", 32'(alu_cntrl), 32'd0);
        check("rst_z_lo", z_lo, 32'd0);
        check("rst_bus_last", 32'(bus_last), 32'd0);
        check("rst_op_err", 32'(op_err), 32'd0);
        @(negedge clock);
        clear_n = 1'b1;
        tick();
        check("rel_op_ready", 32'(op_ready), 32'd1);

        // ADD: single beat, latency 2
        issue(32'd5, 32'd7, 4'd2);
        check("add_ready_low", 32'(op_ready), 32'd0);
        wait_valid("add_lat", 2);
        get_beat("add", 32'd12, 1'b1, 0);
        check("add_z_lo", z_lo, 32'd12);
        check("add_z_hi", z_hi, 32'd0);
        check("add_valid_drop", 32'(bus_valid), 32'd0);
        check("add_idle_ready", 32'(op_ready), 32'd1);

        // MUL: two beats, latency 5
        issue(32'h0001_0000, 32'h0001_0000, 4'd10);
        wait_valid("mul_lat", 5);
        get_beat("mul_lo", 32'h0, 1'b0, 0);
        get_beat("mul_hi", 32'h1, 1'b1, 0);
        check("mul_z_hi", z_hi, 32'h1);
        check("mul_valid_drop", 32'(bus_valid), 32'd0);

        // DIV with 3 cycles of backpressure on the first beat
        issue(32'd100, 32'd7, 4'd11);
        get_beat("div_lo", 32'd14, 1'b0, 3);
        get_beat("div_hi", 32'd2, 1'b1, 0);
        check("div_z_lo", z_lo, 32'd14);
        check("div_valid_drop", 32'(bus_valid), 32'd0);

        // Reset during the settle window of a MUL
        issue(32'd3, 32'd9, 4'd10);
        tick();
        clear_n = 1'b0;
        #2;
        check("midrst_valid", 32'(bus_valid), 32'd0);
        check("midrst_z_lo", z_lo, 32'd0);
        check("midrst_z_hi", z_hi, 32'd0);
        check("midrst_alu_a", alu_a, 32'd0);
        @(negedge clock);
        clear_n = 1'b1;
        tick();
        check("midrst_ready", 32'(op_ready), 32'd1);
        seen_valid = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus_valid) seen_valid = 1;
            tick();
        end
        check("midrst_no_beat", 32'(seen_valid), 32'd0);

        // Illegal opcode: zero beat, sticky error
        issue(32'd3, 32'd4, 4'd13);
        get_beat("inv", 32'd0, 1'b1, 0);
        check("inv_err", 32'(op_err), 32'd1);
        issue(32'd1, 32'd1, 4'd2);
        get_beat("inv_add", 32'd2, 1'b1, 0);
        check("inv_err_sticky", 32'(op_err), 32'd1);

        // Three back-to-back ORs with op_valid held high
        op_valid = 1'b1;
        op_cntrl = 4'd1;
        for (int i = 0; i < 3; i++) begin
            int n;
            op_a = or_a[i];
            op_b = or_b[i];
            n = 0;
            while (!op_ready && n < 40) begin
                tick();
                n++;
            end
            check("or_ready", 32'(op_ready), 32'd1);
            tick();
            op_a = 32'hFFFF_FFFF;
            op_b = 32'hFFFF_FFFF;
            check("or_busy", 32'(op_ready), 32'd0);
            tick();
            check("or_alu_a", alu_a, or_a[i]);
            check("or_alu_b", alu_b, or_b[i]);
            get_beat("or", or_a[i] | or_b[i], 1'b1, 0);
        end
        op_valid = 1'b0;
        tick();
        check("or_end_idle", 32'(bus_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
